// File: rtl/ram_pkg.sv
// ram_pkg: shared types, default sizes and the byte-merge helper for
// param_sp_ram and its read pipeline stage.
//   ram_state_e    : controller state (CLEAR = hardware zero-fill, RUN = normal)
//   RAM_DATA_W     : default data width
//   RAM_DEPTH      : default number of words
//   RAM_MAX_DATA_W : widest data word the merge helper supports
//   byte_merge()   : replaces the bytes of old_d selected by mask with new_d
package ram_pkg;

  localparam int RAM_DATA_W     = 32;
  localparam int RAM_DEPTH      = 16;
  localparam int RAM_MAX_DATA_W = 256;
  localparam int RAM_MAX_BE_W   = RAM_MAX_DATA_W / 8;

  typedef enum logic {
    CLEAR,
    RUN
  } ram_state_e;

  // Works on the widest supported word; callers zero-extend their operands
  // and truncate the result back to their own width.
  function automatic logic [RAM_MAX_DATA_W-1:0] byte_merge(
    input logic [RAM_MAX_DATA_W-1:0] old_d,
    input logic [RAM_MAX_DATA_W-1:0] new_d,
    input logic [RAM_MAX_BE_W-1:0]   mask
  );
    logic [RAM_MAX_DATA_W-1:0] r;
    r = old_d;
    for (int i = 0; i < RAM_MAX_BE_W; i++) begin
      if (mask[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: one register stage carrying a read result {data, valid, err}.
// The data register only loads on a valid result so the output holds the
// last read value between reads.
//   clk, rst          : clock, synchronous active-high reset
//   d_in/valid_in/err_in    : result from the previous stage
//   d_out/valid_out/err_out : the same, one cycle later
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in,
  input  logic              valid_in,
  input  logic              err_in,
  output logic [DATA_W-1:0] d_out,
  output logic              valid_out,
  output logic              err_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out     <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      valid_out <= valid_in;
      err_out   <= err_in;
      if (valid_in) d_out <= d_in;
    end
  end

endmodule

// File: rtl/param_sp_ram.sv
// param_sp_ram: parametrised single-port synchronous RAM with per-byte write
// enables, 1- or 2-cycle read latency and an optional sequenced zero-fill
// after reset.
//   clk, rst   : clock, synchronous active-high reset
//   en, write  : request valid / 1 = write, 0 = read
//   address    : word address (values >= DEPTH are out of range)
//   data       : write data, byte_en : per-byte write mask
//   data_out   : read data (holds last read), valid_out : new read result
//   ready      : requests accepted, err : out-of-range request pulse
module param_sp_ram
  import ram_pkg::*;
#(
  parameter int DATA_W       = RAM_DATA_W,
  parameter int DEPTH        = RAM_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                ready,
  output logic                err
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("param_sp_ram: DATA_W must be a multiple of 8");
  end
  if (DATA_W > RAM_MAX_DATA_W) begin : g_wide_data_w
    $error("param_sp_ram: DATA_W exceeds RAM_MAX_DATA_W");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("param_sp_ram: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sp_ram: DEPTH must be at least 2");
  end

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  ram_state_e        state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              clr_we;

  // Clear sequencer: one word per cycle, then RUN.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_WORD) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: ;
    endcase
  end

  // ready is registered so it is low through reset even when no clear runs.
  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= (state_next == RUN);
    end
  end

  logic accept, in_range, wr_ok;
  assign accept   = en & ready & ~rst;
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign wr_ok    = accept & write & in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset term; zeroing is done word by word by the
  // clear sequencer so the array maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[address] <= DATA_W'(byte_merge(RAM_MAX_DATA_W'(mem[address]),
                                         RAM_MAX_DATA_W'(data),
                                         RAM_MAX_BE_W'(byte_en)));
    end
  end

  // Request stage: the array is read one edge after the request is sampled,
  // which is what lets a write at edge N be seen by a read sampled at N+1.
  // Out-of-range writes travel down the same pipe as reads so every err
  // pulse owns its own slot.
  logic              rq_rd, rq_err, rq_oor;
  logic [ADDR_W-1:0] rq_addr;
  logic              s1_valid, s1_err;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_rd    <= 1'b0;
      rq_err   <= 1'b0;
      rq_oor   <= 1'b0;
      rq_addr  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      rq_rd    <= accept & ~write;
      rq_err   <= accept & ~in_range;
      rq_oor   <= ~in_range;
      rq_addr  <= address;
      s1_valid <= rq_rd;
      s1_err   <= rq_err;
      if (rq_rd) s1_data <= rq_oor ? '0 : mem[rq_addr];
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    ram_rd_pipe #(.DATA_W(DATA_W)) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .d_in     (s1_data),
      .valid_in (s1_valid),
      .err_in   (s1_err),
      .d_out    (data_out),
      .valid_out(valid_out),
      .err_out  (err)
    );
  end else begin : g_lat1
    assign data_out  = s1_data;
    assign valid_out = s1_valid;
    assign err       = s1_err;
  end

endmodule

// File: tb/tb_param_sp_ram.sv
// tb_param_sp_ram: self-checking bench for param_sp_ram.
//   dut 0 : defaults (32x16, RD_LAT=1, CLEAR_ON_RST=1)
//   dut 1 : DEPTH=12, RD_LAT=2, CLEAR_ON_RST=0
// Read results are predicted into a per-DUT queue when the read is driven and
// popped by a negedge monitor whenever valid_out is seen.
module tb_param_sp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        en   [2];
  logic        wr   [2];
  logic [3:0]  addr [2];
  logic [31:0] din  [2];
  logic [3:0]  be   [2];
  logic [31:0] dout [2];
  logic        vout [2];
  logic        rdy  [2];
  logic        err  [2];

  param_sp_ram u_a (
    .clk(clk), .rst(rst[0]), .en(en[0]), .write(wr[0]), .address(addr[0]),
    .data(din[0]), .byte_en(be[0]), .data_out(dout[0]), .valid_out(vout[0]),
    .ready(rdy[0]), .err(err[0])
  );

  param_sp_ram #(.DEPTH(12), .RD_LAT(2), .CLEAR_ON_RST(0)) u_b (
    .clk(clk), .rst(rst[1]), .en(en[1]), .write(wr[1]), .address(addr[1]),
    .data(din[1]), .byte_en(be[1]), .data_out(dout[1]), .valid_out(vout[1]),
    .ready(rdy[1]), .err(err[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  exp_t sbq [2][$];
  int   werr_pend [2];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int d);
    en[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  task automatic req(input int d, input logic w, input logic [3:0] a,
                     input logic [31:0] dat, input logic [3:0] m);
    en[d]   = 1'b1;
    wr[d]   = w;
    addr[d] = a;
    din[d]  = dat;
    be[d]   = m;
  endtask

  task automatic rd(input int d, input logic [3:0] a, input logic [31:0] e, input logic ee);
    exp_t x;
    req(d, 1'b0, a, 32'h0, 4'h0);
    x.data = e;
    x.err  = ee;
    sbq[d].push_back(x);
  endtask

  function automatic logic [31:0] b_pat(input int i);
    return (i <= 3) ? 32'(i) : (32'hA000_0000 | 32'(i));
  endfunction

  // Called at the negedge right after a reset edge of dut 0, with rst low.
  // ready must stay low for 16 samples and rise on the 17th; requests driven
  // meanwhile must be ignored (the writes to word 0 must never land).
  task automatic wait_clear_a(input string tag, input bit chk_b);
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("%s ready[%0d]", tag, i), rdy[0], (i == 16));
      if (chk_b && i <= 1) check($sformatf("%s b ready[%0d]", tag, i), rdy[1], (i == 1));
      if (i < 16) begin
        if (i % 2 == 0) req(0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF);
        else            req(0, 1'b0, 4'd5, 32'h0, 4'h0);
        @(negedge clk);
      end else begin
        idle(0);
      end
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vout[d] === 1'b1) begin
        if (sbq[d].size() == 0) begin
          check($sformatf("dut%0d unexpected valid_out", d), vout[d], 1'b0);
        end else begin : pop_blk
          exp_t e;
          e = sbq[d].pop_front();
          check($sformatf("dut%0d read data", d), dout[d], e.data);
          check($sformatf("dut%0d read err", d), err[d], e.err);
        end
      end else if (err[d] === 1'b1) begin
        if (werr_pend[d] > 0) werr_pend[d]--;
        else check($sformatf("dut%0d unexpected err", d), err[d], 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  32'hAABB_CCDD, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 4'd3,  32'h1122_3344, 4'h5, 32'h0};
    vecs[2]  = '{1'b0, 4'd3,  32'h0,         4'h0, 32'hAA22_CC44};
    vecs[3]  = '{1'b1, 4'd7,  32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 4'd7,  32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 4'd9,  32'h1234_5678, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 4'd9,  32'h0,         4'h0, 32'h0};
    vecs[7]  = '{1'b1, 4'd9,  32'hCAFE_F00D, 4'h8, 32'h0};
    vecs[8]  = '{1'b0, 4'd9,  32'h0,         4'h0, 32'hCA00_0000};
    vecs[9]  = '{1'b1, 4'd15, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 4'd15, 32'h0,         4'h0, 32'hFFFF_FFFF};
    vecs[11] = '{1'b0, 4'd0,  32'h0,         4'h0, 32'h0};
    vecs[12] = '{1'b1, 4'd0,  32'h0000_A5A5, 4'h3, 32'h0};
    vecs[13] = '{1'b0, 4'd0,  32'h0,         4'h0, 32'h0000_A5A5};
    vecs[14] = '{1'b0, 4'd3,  32'h0,         4'h0, 32'hAA22_CC44};
    vecs[15] = '{1'b0, 4'd7,  32'h0,         4'h0, 32'hDEAD_BEEF};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      idle(d);
      addr[d] = '0;
      din[d]  = '0;
      be[d]   = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset data_out", d),  dout[d], 32'h0);
      check($sformatf("dut%0d reset valid_out", d), vout[d], 1'b0);
      check($sformatf("dut%0d reset err", d),       err[d],  1'b0);
      check($sformatf("dut%0d reset ready", d),     rdy[d],  1'b0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    wait_clear_a("init", 1'b1);

    // Every word of dut 0 reads back zero after the clear.
    for (int a = 0; a < 16; a++) begin
      rd(0, 4'(a), 32'h0, 1'b0);
      @(negedge clk);
    end
    idle(0);
    repeat (3) @(negedge clk);

    // Table-driven writes/reads, one request per cycle.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) req(0, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].be);
      else            rd(0, vecs[i].addr, vecs[i].exp, 1'b0);
      @(negedge clk);
    end
    idle(0);
    repeat (3) @(negedge clk);

    // Exact RD_LAT=1 timing, then a write must leave data_out untouched.
    rd(0, 4'd7, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    idle(0);
    check("a lat1 valid at N", vout[0], 1'b0);
    @(negedge clk);
    check("a lat1 valid at N+1", vout[0], 1'b1);
    check("a lat1 data at N+1", dout[0], 32'hDEAD_BEEF);
    @(negedge clk);
    check("a lat1 valid at N+2", vout[0], 1'b0);
    req(0, 1'b1, 4'd7, 32'h1234_5678, 4'hF);
    @(negedge clk);
    idle(0);
    @(negedge clk);
    @(negedge clk);
    check("a write holds data_out", dout[0], 32'hDEAD_BEEF);
    check("a write no valid_out", vout[0], 1'b0);

    // Reset at clear count 5: the clear restarts from word 0.
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    wait_clear_a("midclear", 1'b0);
    rd(0, 4'd3, 32'h0, 1'b0);
    @(negedge clk);
    idle(0);
    repeat (3) @(negedge clk);

    // Reset one cycle after a read: the result must never appear.
    req(0, 1'b0, 4'd7, 32'h0, 4'h0);
    @(negedge clk);
    idle(0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("a inflight flushed valid", vout[0], 1'b0);
    wait_clear_a("inflight", 1'b0);

    // dut 1: preload, then RD_LAT=2 timing on addr 1,2,3.
    for (int i = 0; i < 12; i++) begin
      req(1, 1'b1, 4'(i), b_pat(i), 4'hF);
      @(negedge clk);
    end
    rd(1, 4'd1, 32'h1, 1'b0);
    @(negedge clk);
    check("b lat2 valid at N", vout[1], 1'b0);
    rd(1, 4'd2, 32'h2, 1'b0);
    @(negedge clk);
    check("b lat2 valid at N+1", vout[1], 1'b0);
    rd(1, 4'd3, 32'h3, 1'b0);
    @(negedge clk);
    idle(1);
    check("b lat2 valid at N+2", vout[1], 1'b1);
    check("b lat2 data at N+2", dout[1], 32'h1);
    @(negedge clk);
    check("b lat2 valid at N+3", vout[1], 1'b1);
    check("b lat2 data at N+3", dout[1], 32'h2);
    @(negedge clk);
    check("b lat2 valid at N+4", vout[1], 1'b1);
    check("b lat2 data at N+4", dout[1], 32'h3);
    @(negedge clk);
    check("b lat2 valid at N+5", vout[1], 1'b0);

    // Out-of-range write: err pulse only, memory unchanged.
    req(1, 1'b1, 4'd13, 32'h5, 4'hF);
    werr_pend[1]++;
    @(negedge clk);
    idle(1);
    check("b oor write err at N", err[1], 1'b0);
    @(negedge clk);
    check("b oor write err at N+1", err[1], 1'b0);
    @(negedge clk);
    check("b oor write err at N+2", err[1], 1'b1);
    check("b oor write no valid", vout[1], 1'b0);
    @(negedge clk);
    check("b oor write err ends", err[1], 1'b0);

    // Out-of-range read returns zero with valid and err together.
    rd(1, 4'd13, 32'h0, 1'b1);
    @(negedge clk);
    idle(1);
    repeat (2) @(negedge clk);
    check("b oor read valid", vout[1], 1'b1);
    check("b oor read data", dout[1], 32'h0);
    check("b oor read err", err[1], 1'b1);
    @(negedge clk);

    // Whole array plus the first out-of-range address.
    for (int a = 0; a <= 12; a++) begin
      rd(1, 4'(a), (a < 12) ? b_pat(a) : 32'h0, (a >= 12));
      @(negedge clk);
    end
    idle(1);
    repeat (4) @(negedge clk);

    // dut 1 reset with a read in flight.
    req(1, 1'b0, 4'd2, 32'h0, 4'h0);
    @(negedge clk);
    idle(1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("b inflight valid after rst", vout[1], 1'b0);
    check("b ready low after rst", rdy[1], 1'b0);
    @(negedge clk);
    check("b inflight valid later", vout[1], 1'b0);
    check("b ready after one edge", rdy[1], 1'b1);
    repeat (3) @(negedge clk);

    check("a scoreboard drained", sbq[0].size(), 0);
    check("b scoreboard drained", sbq[1].size(), 0);
    check("b write err seen", werr_pend[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
